light_monitor: RTL and testbench
================================

Name: light_monitor

Overview:
Safety monitor on the lamp side of the traffic-light controller interface. It consumes the per-approach lamp vectors and pedestrian-green lines that top_level drives, and checks them against the legal phase sequence and timing rules. It latches the first violation, reports it through a valid/ack handshake and raises attention_req. attention_req is intended to feed the controller's attention input.

Parameters:
NUM_LIGHTS, 4, number of approaches monitored
MIN_YELLOW, 3, minimum consecutive cycles a lamp must show yellow before red
CNT_W, 8, width of the saturating fault counter

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
ltfs  input  [NUM_LIGHTS-1:0][0:2]  lamp vector per approach; bit0=red, bit1=yellow, bit2=green; 000=dark
lgreen  input  NUM_LIGHTS  pedestrian green per approach
fault_ack  input  1  single-cycle acknowledge of the reported fault
fault_valid  output  1  a fault is latched and being reported
fault_code  output  3  fault type (see Behaviour)
fault_light  output  $clog2(NUM_LIGHTS)  approach index of the reported fault
attention_req  output  1  equals fault_valid, registered
fault_count  output  CNT_W  total faults detected since reset, saturating

Behaviour:
- Reset (rst=1 at posedge): all outputs 0; every per-lamp tracker goes to OFF; yellow counters are cleared. Inputs are ignored while rst=1, and may be X.
- Per-lamp tracker states: OFF, RED, GREEN, YELLOW. The tracker holds the last legal decoded state.
  - A one-hot input moves the tracker to that colour. 000 moves it to OFF.
  - The tracker updates even when a fault is flagged, so one bad edge produces one fault, not a stream.
- Legal transitions: OFF->RED, RED->GREEN, GREEN->YELLOW, YELLOW->RED, any state held. Power-up is staggered (lamps go OFF->RED at different cycles); this is legal.
- Fault codes. Check order within a light is by priority, highest first:
  - 1 ENCODING: more than one bit set in ltfs[i]. The tracker keeps its previous state.
  - 2 TRANSITION: any other colour change, e.g. GREEN->RED, RED->YELLOW, OFF->GREEN.
  - 3 DARK: non-OFF->000.
  - 4 SHORT_YELLOW: YELLOW->RED with yellow count < MIN_YELLOW.
  - 5 CONFLICT: green on more than one approach in the same cycle. fault_light is the lowest index that is green.
  - 6 PED: lgreen[i]=1 while ltfs[i] is green.
- Yellow counter per lamp:
  - Loads 1 on entry to YELLOW.
  - Increments each held YELLOW cycle, saturating at MIN_YELLOW.
  - Cleared when the lamp leaves YELLOW.
- Several faults in one cycle: report the lowest code; ties are broken by the lowest light index. fault_count increments by 1 per cycle with at least one fault, not once per fault.
- Latency: a fault on the inputs sampled at edge N gives fault_valid, code and light visible after edge N+1 (one registered stage after the tracker compare).
- Report FSM:
  - IDLE -> HOLD on a detected fault.
  - In HOLD, outputs are frozen. Further faults only increment fault_count.
  - HOLD -> IDLE on fault_ack.
  - fault_ack in the same cycle as a new fault: the new fault is loaded and the FSM stays in HOLD.
  - fault_ack in IDLE is ignored.
- fault_count saturates at all-ones and does not wrap.
- rst mid-HOLD clears the report FSM and all outputs in the same edge. Trackers return to OFF, so the following power-up sequence is legal.

Decomposition:
- Package light_pkg holds:
  - the colour encoding localparams (RED=3'b100, YELLOW=3'b010, GREEN=3'b001, DARK=3'b000, as bit [0:2] order);
  - the lamp_state_t enum {OFF, RED, GREEN, YELLOW};
  - the fault_code_t enum with the values listed above.
- Sub-module lamp_tracker holds one instance per approach: the decode, state register, yellow counter and per-lamp fault flags.
- The top level handles conflict/pedestrian checks, the priority encoder, the report FSM and the counter.

Test Plan:
1. Staggered power-up. After rst, lamps go 000->100 one at a time; approach 0 then runs 100->001->010 (held 3 cycles)->100. Required: fault_valid stays 0 throughout and fault_count=0.
2. Skipped yellow. Approach 1 goes 001->100. Required: after the next edge, fault_valid=1, code=2, light=1, attention_req=1. Outputs hold until fault_ack, then fault_valid=0 on the following edge.
3. Short yellow. Approach 2 goes 001->010 (1 cycle)->100 with MIN_YELLOW=3. Required: code=4, light=2, fault_count=1.
4. Conflict plus encoding in the same cycle. Approaches 0 and 3 are both 001 and approach 1 is 110. Required: code=1, light=1, fault_count increments by exactly 1. The next cycle with the same stimulus (still in HOLD) leaves outputs frozen and fault_count increments.
5. Ack collision. During HOLD, pulse fault_ack while lgreen[0]=1 and ltfs[0]=001. Required: fault_valid stays 1, code=6, light=0.
6. Reset during HOLD. rst=1 for 2 cycles with X inputs. Required: all outputs 0; a subsequent clean power-up produces no fault.

Source files
------------

// File: rtl/light_pkg.sv
// Shared encodings for the lamp-side safety monitor: colour vectors,
// tracker states, fault codes and the small helpers used to classify edges.
package light_pkg;

  // Lamp vectors are indexed [0:2] = {red, yellow, green}.
  localparam logic [0:2] RED    = 3'b100;
  localparam logic [0:2] YELLOW = 3'b010;
  localparam logic [0:2] GREEN  = 3'b001;
  localparam logic [0:2] DARK   = 3'b000;

  typedef enum logic [1:0] {
    LS_OFF,
    LS_RED,
    LS_GREEN,
    LS_YELLOW
  } lamp_state_t;

  typedef enum logic [2:0] {
    FC_NONE         = 3'd0,
    FC_ENCODING     = 3'd1,
    FC_TRANSITION   = 3'd2,
    FC_DARK         = 3'd3,
    FC_SHORT_YELLOW = 3'd4,
    FC_CONFLICT     = 3'd5,
    FC_PED          = 3'd6
  } fault_code_t;

  typedef enum logic {
    RPT_IDLE,
    RPT_HOLD
  } report_state_t;

  function automatic lamp_state_t decode_lamp(logic [0:2] lamp);
    case (lamp)
      RED:     return LS_RED;
      YELLOW:  return LS_YELLOW;
      GREEN:   return LS_GREEN;
      default: return LS_OFF;
    endcase
  endfunction

  // Only the forward phase cycle is legal; holding is handled by the caller.
  function automatic logic legal_step(lamp_state_t from, lamp_state_t to);
    case (from)
      LS_OFF:    return to == LS_RED;
      LS_RED:    return to == LS_GREEN;
      LS_GREEN:  return to == LS_YELLOW;
      LS_YELLOW: return to == LS_RED;
      default:   return 1'b0;
    endcase
  endfunction

  // Lower code wins; FC_NONE never beats anything.
  function automatic logic better(fault_code_t cand, fault_code_t cur);
    return (cand != FC_NONE) && ((cur == FC_NONE) || (cand < cur));
  endfunction

endpackage

// File: rtl/light_monitor_lamp_tracker.sv
// One approach: decodes the lamp vector, tracks the last legal colour and
// the yellow dwell count, and flags this lamp's own sequencing faults.
module lamp_tracker
  import light_pkg::*;
#(
  parameter int MIN_YELLOW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:2]  lamp,
  output fault_code_t fault
);

  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam logic [YW-1:0] Y_MAX = YW'(MIN_YELLOW);

  lamp_state_t   state;
  lamp_state_t   dec;
  logic          multi;
  logic [YW-1:0] ycnt;

  always_comb begin
    multi = ($countones(lamp) > 1);
    dec   = decode_lamp(lamp);
    fault = FC_NONE;
    if (multi) begin
      fault = FC_ENCODING;
    end else if (dec != state) begin
      if (dec == LS_OFF) begin
        fault = FC_DARK;
      end else if (!legal_step(state, dec)) begin
        fault = FC_TRANSITION;
      end else if ((state == LS_YELLOW) && (ycnt < Y_MAX)) begin
        fault = FC_SHORT_YELLOW;
      end
    end
  end

  // The tracker follows the input even on faulting edges so a single bad
  // edge is reported once; an unreadable vector leaves everything as is.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LS_OFF;
      ycnt  <= '0;
    end else if (!multi) begin
      state <= dec;
      if (dec == LS_YELLOW) begin
        if (state != LS_YELLOW) begin
          ycnt <= YW'(1);
        end else if (ycnt != Y_MAX) begin
          ycnt <= ycnt + YW'(1);
        end
      end else begin
        ycnt <= '0;
      end
    end
  end

endmodule

// File: rtl/light_monitor.sv
// Lamp-side safety monitor: per-approach trackers, cross-approach checks,
// one-stage fault capture and a first-fault report held until acknowledged.
//   state    | meaning
//   RPT_IDLE | nothing latched, outputs zero
//   RPT_HOLD | fault latched and reported, frozen until fault_ack
module light_monitor
  import light_pkg::*;
#(
  parameter int NUM_LIGHTS = 4,
  parameter int MIN_YELLOW = 3,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_LIGHTS-1:0][0:2]    ltfs,
  input  logic [NUM_LIGHTS-1:0]         lgreen,
  input  logic                          fault_ack,
  output logic                          fault_valid,
  output logic [2:0]                    fault_code,
  output logic [$clog2(NUM_LIGHTS)-1:0] fault_light,
  output logic                          attention_req,
  output logic [CNT_W-1:0]              fault_count
);

  localparam int LW = $clog2(NUM_LIGHTS);

  fault_code_t   lamp_fault [NUM_LIGHTS];
  fault_code_t   det_code_c;
  logic [LW-1:0] det_light_c;
  logic          seen_green;
  logic          multi_green;
  logic [LW-1:0] first_green;

  logic          det_valid;
  fault_code_t   det_code;
  logic [LW-1:0] det_light;

  report_state_t rpt_q, rpt_d;
  fault_code_t   code_q, code_d;
  logic [LW-1:0] light_q, light_d;
  logic          attn_q;
  logic [CNT_W-1:0] cnt_q;

  for (genvar g = 0; g < NUM_LIGHTS; g++) begin : g_lamp
    lamp_tracker #(
      .MIN_YELLOW(MIN_YELLOW)
    ) u_trk (
      .clk  (clk),
      .rst  (rst),
      .lamp (ltfs[g]),
      .fault(lamp_fault[g])
    );
  end

  // Ascending index with a strict "better" compare breaks ties low.
  always_comb begin
    det_code_c  = FC_NONE;
    det_light_c = '0;
    seen_green  = 1'b0;
    multi_green = 1'b0;
    first_green = '0;
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      if (better(lamp_fault[i], det_code_c)) begin
        det_code_c  = lamp_fault[i];
        det_light_c = LW'(i);
      end
      if (ltfs[i] == GREEN) begin
        if (seen_green) begin
          multi_green = 1'b1;
        end else begin
          first_green = LW'(i);
        end
        seen_green = 1'b1;
        if (lgreen[i] && better(FC_PED, det_code_c)) begin
          det_code_c  = FC_PED;
          det_light_c = LW'(i);
        end
      end
    end
    if (multi_green && better(FC_CONFLICT, det_code_c)) begin
      det_code_c  = FC_CONFLICT;
      det_light_c = first_green;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      det_valid <= 1'b0;
      det_code  <= FC_NONE;
      det_light <= '0;
    end else begin
      det_valid <= (det_code_c != FC_NONE);
      det_code  <= det_code_c;
      det_light <= det_light_c;
    end
  end

  // An ack coinciding with a fresh fault replaces the report instead of
  // dropping to idle, so no fault slips through between reports.
  always_comb begin
    rpt_d   = rpt_q;
    code_d  = code_q;
    light_d = light_q;
    if (det_valid && ((rpt_q == RPT_IDLE) || fault_ack)) begin
      rpt_d   = RPT_HOLD;
      code_d  = det_code;
      light_d = det_light;
    end else if ((rpt_q == RPT_HOLD) && fault_ack) begin
      rpt_d   = RPT_IDLE;
      code_d  = FC_NONE;
      light_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_q   <= RPT_IDLE;
      code_q  <= FC_NONE;
      light_q <= '0;
      attn_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      rpt_q   <= rpt_d;
      code_q  <= code_d;
      light_q <= light_d;
      attn_q  <= (rpt_d == RPT_HOLD);
      if (det_valid && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign fault_valid   = (rpt_q == RPT_HOLD);
  assign fault_code    = code_q;
  assign fault_light   = light_q;
  assign attention_req = attn_q;
  assign fault_count   = cnt_q;

endmodule

// File: tb/tb_light_monitor.sv
// Bench for light_monitor: directed scenarios with literal expectations, then
// randomized lamp traffic compared every cycle against a phase-rule model.
module tb_light_monitor;

  localparam int NL = 4;
  localparam int MY = 3;
  localparam int CW = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NL-1:0][0:2]   ltfs;
  logic [NL-1:0]        lgreen;
  logic                 fault_ack;
  logic                 fault_valid;
  logic [2:0]           fault_code;
  logic [1:0]           fault_light;
  logic                 attention_req;
  logic [CW-1:0]        fault_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [0:2] m_col [NL];
  int  m_ycnt [NL];
  bit  m_det;
  int  m_dcode, m_dlight;
  bit  m_valid;
  int  m_code, m_light, m_count;

  always #5 clk = ~clk;

  light_monitor #(.NUM_LIGHTS(NL), .MIN_YELLOW(MY), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ltfs         (ltfs),
    .lgreen       (lgreen),
    .fault_ack    (fault_ack),
    .fault_valid  (fault_valid),
    .fault_code   (fault_code),
    .fault_light  (fault_light),
    .attention_req(attention_req),
    .fault_count  (fault_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Next colour in the legal phase cycle: dark->red->green->yellow->red.
  function automatic logic [0:2] succ(logic [0:2] c);
    case (c)
      3'b000:  return 3'b100;
      3'b100:  return 3'b001;
      3'b001:  return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic take(input int c, input int i, inout int bc, inout int bl);
    if (c < bc) begin
      bc = c;
      bl = i;
    end
  endtask

  task automatic model_step();
    int bc, bl, fg;
    bit seen, multi;
    logic [0:2] v;
    if (rst) begin
      for (int i = 0; i < NL; i++) begin m_col[i] = 3'b000; m_ycnt[i] = 0; end
      m_det = 0; m_dcode = 0; m_dlight = 0;
      m_valid = 0; m_code = 0; m_light = 0; m_count = 0;
      return;
    end
    // report stage acts on what the capture stage saw one edge earlier
    if (m_det) begin
      if (m_count < 255) m_count++;
      if (!m_valid || fault_ack) begin
        m_valid = 1; m_code = m_dcode; m_light = m_dlight;
      end
    end else if (m_valid && fault_ack) begin
      m_valid = 0; m_code = 0; m_light = 0;
    end
    bc = 7; bl = 0; fg = 0; seen = 0; multi = 0;
    for (int i = 0; i < NL; i++) begin
      v = ltfs[i];
      if ($countones(v) > 1) take(1, i, bc, bl);
      else if (v != m_col[i]) begin
        if (v == succ(m_col[i])) begin
          if (m_col[i] == 3'b010 && m_ycnt[i] < MY) take(4, i, bc, bl);
        end else if (v == 3'b000) take(3, i, bc, bl);
        else take(2, i, bc, bl);
      end
      if (v == 3'b001) begin
        if (seen) multi = 1; else fg = i;
        seen = 1;
        if (lgreen[i]) take(6, i, bc, bl);
      end
    end
    if (multi) take(5, fg, bc, bl);
    for (int i = 0; i < NL; i++) begin
      v = ltfs[i];
      if ($countones(v) <= 1) begin
        if (v == 3'b010) m_ycnt[i] = (m_col[i] == 3'b010) ? ((m_ycnt[i] < MY) ? m_ycnt[i] + 1 : MY) : 1;
        else m_ycnt[i] = 0;
        m_col[i] = v;
      end
    end
    m_det = (bc < 7); m_dcode = (bc < 7) ? bc : 0; m_dlight = bl;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("fault_valid", fault_valid, m_valid);
    chk("fault_code", fault_code, m_code);
    chk("fault_light", fault_light, m_light);
    chk("attention_req", attention_req, m_valid);
    chk("fault_count", fault_count, m_count);
  endtask

  task automatic do_reset();
    rst = 1; ltfs = 'x; lgreen = 'x; fault_ack = 1'bx;
    cyc(); cyc();
    rst = 0; ltfs = '0; lgreen = '0; fault_ack = 0;
    cyc();
  endtask

  task automatic powerup();
    for (int i = 0; i < NL; i++) begin
      ltfs[i] = 3'b100;
      cyc();
    end
    cyc();
  endtask

  initial begin
    ltfs = '0; lgreen = '0; fault_ack = 0;

    // 1: staggered power-up and a full legal cycle on approach 0
    do_reset();
    chk("reset_valid", fault_valid, 0);
    chk("reset_count", fault_count, 0);
    powerup();
    ltfs[0] = 3'b001; cyc();
    ltfs[0] = 3'b010; cyc(); cyc(); cyc();
    ltfs[0] = 3'b100; cyc(); cyc();
    chk("t1_valid", fault_valid, 0);
    chk("t1_count", fault_count, 0);

    // 2: green straight to red on approach 1
    ltfs[1] = 3'b001; cyc();
    ltfs[1] = 3'b100; cyc(); cyc();
    chk("t2_valid", fault_valid, 1);
    chk("t2_code", fault_code, 2);
    chk("t2_light", fault_light, 1);
    chk("t2_attn", attention_req, 1);
    cyc(); cyc();
    chk("t2_held", fault_valid, 1);
    fault_ack = 1; cyc();
    fault_ack = 0;
    chk("t2_acked", fault_valid, 0);
    chk("t2_count", fault_count, 1);

    // 3: one-cycle yellow on approach 2
    do_reset(); powerup();
    ltfs[2] = 3'b001; cyc();
    ltfs[2] = 3'b010; cyc();
    ltfs[2] = 3'b100; cyc(); cyc();
    chk("t3_code", fault_code, 4);
    chk("t3_light", fault_light, 2);
    chk("t3_count", fault_count, 1);

    // 4: conflict and bad encoding in the same cycle
    do_reset(); powerup();
    ltfs[0] = 3'b001; ltfs[3] = 3'b001; ltfs[1] = 3'b110;
    cyc(); cyc();
    chk("t4_code", fault_code, 1);
    chk("t4_light", fault_light, 1);
    chk("t4_count", fault_count, 1);
    cyc();
    chk("t4_frozen_code", fault_code, 1);
    chk("t4_count2", fault_count, 2);

    // 5: ack coincides with a new pedestrian fault
    do_reset(); powerup();
    ltfs[0] = 3'b001; cyc();
    ltfs[1] = 3'b110; cyc();
    ltfs[1] = 3'b100; cyc();
    chk("t5_first_code", fault_code, 1);
    lgreen[0] = 1; cyc();
    fault_ack = 1; cyc();
    fault_ack = 0;
    chk("t5_valid", fault_valid, 1);
    chk("t5_code", fault_code, 6);
    chk("t5_light", fault_light, 0);
    chk("t5_count", fault_count, 2);
    lgreen = '0;

    // 6: reset while holding, then a clean power-up
    rst = 1; ltfs = 'x; lgreen = 'x; fault_ack = 1'bx;
    cyc();
    chk("t6_valid", fault_valid, 0);
    chk("t6_code", fault_code, 0);
    chk("t6_count", fault_count, 0);
    cyc();
    rst = 0; ltfs = '0; lgreen = '0; fault_ack = 0;
    cyc();
    powerup();
    chk("t6_clean_valid", fault_valid, 0);
    chk("t6_clean_count", fault_count, 0);

    // randomized traffic, mostly legal phase steps
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NL; i++) begin
        int r;
        logic [0:2] nv;
        r = $urandom_range(0, 99);
        if (r < 60) nv = m_col[i];
        else if (r < 85) nv = succ(m_col[i]);
        else if (r < 92) nv = 3'b000;
        else nv = 3'($urandom_range(0, 7));
        ltfs[i] = nv;
        lgreen[i] = ($urandom_range(0, 19) == 0);
      end
      fault_ack = ($urandom_range(0, 9) < 3);
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 0; fault_ack = 0; lgreen = '0;

    // counter saturation under a continuous fault stream
    do_reset(); powerup();
    for (int i = 0; i < NL; i++) ltfs[i] = 3'b110;
    repeat (300) cyc();
    chk("sat_count", fault_count, 255);
    chk("sat_code", fault_code, 1);
    chk("sat_light", fault_light, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
